// File: rtl/filt_sched.sv
// filt_sched: frame sequencer and result collector for the filt symmetric FIR.
// Issues the periodic FILTER strobe, counts outstanding requests against
// Push responses, buffers returned words in a 2-deep FIFO and raises sticky
// protocol error flags.
module filt_sched #(
  parameter int PERIOD  = 256,
  parameter int PHASE   = 128,
  parameter int SKIP    = 2,
  parameter int MAX_OUT = 2,
  parameter int TIMEOUT = 4096,
  parameter int DATA_W  = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Enable,
  input  logic              ClrErr,
  output logic              FILTER,
  input  logic              Push,
  input  logic [DATA_W-1:0] Dout,
  output logic              OutValid,
  output logic [DATA_W-1:0] OutData,
  input  logic              OutReady,
  output logic [1:0]        Outstanding,
  output logic              OverrunErr,
  output logic              SpurErr,
  output logic              DropErr,
  output logic              TimeoutErr
);

  localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int FIDX_W = (SKIP > 0) ? $clog2(SKIP + 1) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0]  CNT_PHASE = CNT_W'(PHASE);
  localparam logic [FIDX_W-1:0] FIDX_SKIP = FIDX_W'(SKIP);
  localparam logic [1:0]        OUT_MAX   = 2'(MAX_OUT);
  localparam logic [15:0]       TO_LIMIT  = 16'(TIMEOUT);

  // Saturating increment of the response-timeout counter.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v >= TO_LIMIT) return TO_LIMIT;
    return v + 16'd1;
  endfunction

  logic [CNT_W-1:0]  cnt;
  logic [FIDX_W-1:0] fidx;
  logic [15:0]       tcnt;
  logic [15:0]       tcnt_nxt;
  logic [1:0]        fifo_cnt;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] tail;

  logic slot, issue, ovr_ev, dec, spur_ev, pop, drop_ev, to_clr, to_ev;

  assign OutValid = (fifo_cnt != 2'd0);
  assign OutData  = head;

  // Per-cycle events derived from the current registered state and inputs.
  always_comb begin
    slot     = Enable && (cnt == CNT_PHASE) && (fidx >= FIDX_SKIP);
    issue    = slot && (Outstanding != OUT_MAX);
    ovr_ev   = slot && (Outstanding == OUT_MAX);
    dec      = Push && (Outstanding != 2'd0);
    spur_ev  = Push && (Outstanding == 2'd0);
    pop      = OutValid && OutReady;
    drop_ev  = Push && (fifo_cnt == 2'd2) && !pop;
    to_clr   = Push || (Outstanding == 2'd0);
    tcnt_nxt = to_clr ? 16'd0 : sat_inc(tcnt);
    // Fires once on the transition into the limit, not while saturated.
    to_ev    = !to_clr && (tcnt != TO_LIMIT) && (tcnt_nxt == TO_LIMIT);
  end

  // Frame counter and saturating frame index; both frozen while Enable is low.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt  <= '0;
      fidx <= '0;
    end else if (Enable) begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        if (fidx < FIDX_SKIP) fidx <= fidx + FIDX_W'(1);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Registered FILTER strobe, outstanding-request count and timeout counter.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      FILTER      <= 1'b0;
      Outstanding <= 2'd0;
      tcnt        <= 16'd0;
    end else begin
      FILTER      <= issue;
      Outstanding <= Outstanding + {1'b0, issue} - {1'b0, dec};
      tcnt        <= tcnt_nxt;
    end
  end

  // Two-entry result FIFO; head is the visible word and holds after draining.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      fifo_cnt <= 2'd0;
      head     <= '0;
      tail     <= '0;
    end else begin
      case (fifo_cnt)
        2'd0: begin
          if (Push) begin
            head     <= Dout;
            fifo_cnt <= 2'd1;
          end
        end
        2'd1: begin
          if (Push && pop) begin
            head <= Dout;
          end else if (pop) begin
            fifo_cnt <= 2'd0;
          end else if (Push) begin
            tail     <= Dout;
            fifo_cnt <= 2'd2;
          end
        end
        default: begin
          // Full: a push without a pop is discarded (flagged below).
          if (pop) begin
            head <= tail;
            if (Push) tail <= Dout;
            else      fifo_cnt <= 2'd1;
          end
        end
      endcase
    end
  end

  // Sticky error flags; a new event wins over a same-cycle clear.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      OverrunErr <= 1'b0;
      SpurErr    <= 1'b0;
      DropErr    <= 1'b0;
      TimeoutErr <= 1'b0;
    end else begin
      OverrunErr <= (OverrunErr & ~ClrErr) | ovr_ev;
      SpurErr    <= (SpurErr    & ~ClrErr) | spur_ev;
      DropErr    <= (DropErr    & ~ClrErr) | drop_ev;
      TimeoutErr <= (TimeoutErr & ~ClrErr) | to_ev;
    end
  end

endmodule

// File: tb/tb_filt_sched.sv
// Self-checking bench for filt_sched: directed scenarios, a vector table for
// the FIFO corner cases and a randomized run, all shadowed by a
// cycle-level reference model of the scheduler rules.
module tb_filt_sched;

  localparam int PERIOD  = 256;
  localparam int PHASE   = 128;
  localparam int SKIP    = 2;
  localparam int MAX_OUT = 2;
  localparam int TIMEOUT = 4096;

  logic        Clock = 1'b0;
  logic        Reset, Enable, ClrErr, Push, OutReady;
  logic [15:0] Dout;
  logic        FILTER, OutValid, OverrunErr, SpurErr, DropErr, TimeoutErr;
  logic [15:0] OutData;
  logic [1:0]  Outstanding;

  int n_chk  = 0;
  int n_fail = 0;

  filt_sched #(
    .PERIOD(PERIOD), .PHASE(PHASE), .SKIP(SKIP),
    .MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT), .DATA_W(16)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .ClrErr(ClrErr),
    .FILTER(FILTER), .Push(Push), .Dout(Dout),
    .OutValid(OutValid), .OutData(OutData), .OutReady(OutReady),
    .Outstanding(Outstanding), .OverrunErr(OverrunErr), .SpurErr(SpurErr),
    .DropErr(DropErr), .TimeoutErr(TimeoutErr)
  );

  always #5 Clock = ~Clock;

  // Reference model state
  int          m_e;      // enabled clock edges since reset
  int          m_out;
  int          m_age;
  logic [15:0] m_q[$];
  logic [15:0] m_hold;
  bit          m_filter, m_ovr, m_spur, m_drop, m_to;

  int fpos[$];
  int next_push;

  typedef struct {
    bit          push;
    logic [15:0] dout;
    bit          rdy;
    bit          clr;
    bit          e_valid;
    logic [15:0] e_data;
    bit          e_drop;
  } vec_t;
  vec_t tv[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_step();
    bit slot, issue, dec, pop, ev_ovr, ev_spur, ev_drop, ev_to;
    int nage;
    if (Reset) begin
      m_e = 0; m_out = 0; m_age = 0; m_q.delete(); m_hold = 16'h0;
      m_filter = 0; m_ovr = 0; m_spur = 0; m_drop = 0; m_to = 0;
      return;
    end
    slot    = Enable && (m_e % PERIOD == PHASE) && (m_e / PERIOD >= SKIP);
    issue   = slot && (m_out < MAX_OUT);
    ev_ovr  = slot && !issue;
    dec     = Push && (m_out > 0);
    ev_spur = Push && (m_out == 0);
    pop     = (m_q.size() > 0) && OutReady;
    ev_drop = Push && (m_q.size() == 2) && !pop;
    if (Push || m_out == 0) nage = 0;
    else nage = (m_age < TIMEOUT) ? m_age + 1 : TIMEOUT;
    ev_to = (nage == TIMEOUT) && (m_age != TIMEOUT);
    m_age = nage;
    m_filter = issue;
    m_out = m_out + int'(issue) - int'(dec);
    if (pop) void'(m_q.pop_front());
    if (Push && !ev_drop) m_q.push_back(Dout);
    if (m_q.size() > 0) m_hold = m_q[0];
    m_ovr  = (m_ovr  && !ClrErr) || ev_ovr;
    m_spur = (m_spur && !ClrErr) || ev_spur;
    m_drop = (m_drop && !ClrErr) || ev_drop;
    m_to   = (m_to   && !ClrErr) || ev_to;
    if (Enable) m_e++;
  endtask

  task automatic check_all();
    chk("m_FILTER",      FILTER,      m_filter);
    chk("m_OutValid",    OutValid,    m_q.size() > 0);
    chk("m_OutData",     OutData,     m_hold);
    chk("m_Outstanding", Outstanding, m_out);
    chk("m_OverrunErr",  OverrunErr,  m_ovr);
    chk("m_SpurErr",     SpurErr,     m_spur);
    chk("m_DropErr",     DropErr,     m_drop);
    chk("m_TimeoutErr",  TimeoutErr,  m_to);
  endtask

  task automatic tick();
    model_step();
    @(posedge Clock);
    #1;
    check_all();
  endtask

  task automatic do_reset(input int n);
    Reset = 1; Enable = 0; Push = 0; ClrErr = 0; OutReady = 0; Dout = 16'h0;
    repeat (n) tick();
    Reset = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_FILTER"},   FILTER,      0);
    chk({tag, "_OutValid"}, OutValid,    0);
    chk({tag, "_OutData"},  OutData,     0);
    chk({tag, "_Outst"},    Outstanding, 0);
    chk({tag, "_Ovr"},      OverrunErr,  0);
    chk({tag, "_Spur"},     SpurErr,     0);
    chk({tag, "_Drop"},     DropErr,     0);
    chk({tag, "_Tmo"},      TimeoutErr,  0);
  endtask

  initial begin
    Reset = 1; Enable = 0; Push = 0; ClrErr = 0; OutReady = 0; Dout = 16'h0;

    // Reset state, FILTER cadence and a filt that answers 200 clocks later
    do_reset(3);
    chk_all_zero("rst");
    Enable = 1; OutReady = 1; Dout = 16'h1234;
    fpos.delete(); next_push = -1;
    for (int k = 1; k <= 1700; k++) begin
      Push = (k == next_push);
      tick();
      if (FILTER) begin
        fpos.push_back(k);
        next_push = k + 200;
      end
      if (k == next_push - 1) chk("t2_out1", Outstanding, 1);
      if (k == next_push) begin
        chk("t2_valid", OutValid, 1);
        chk("t2_data",  OutData,  16'h1234);
        chk("t2_out0",  Outstanding, 0);
      end
    end
    Push = 0;
    chk("t1_npulses", fpos.size(), 5);
    for (int i = 0; i < fpos.size(); i++) chk("t1_pulse_pos", fpos[i], 641 + 256 * i);
    chk("t1_ovr", OverrunErr, 0);
    chk("t1_spur", SpurErr, 0);
    chk("t1_drop", DropErr, 0);
    chk("t1_tmo", TimeoutErr, 0);

    // No responses: overrun on the third slot, timeout 4096 clocks later
    do_reset(2);
    Enable = 1; OutReady = 1;
    fpos.delete();
    for (int k = 1; k <= 4740; k++) begin
      tick();
      if (FILTER) fpos.push_back(k);
      if (k == 898)  chk("t3_out2", Outstanding, 2);
      if (k == 1152) chk("t3_ovr_before", OverrunErr, 0);
      if (k == 1153) begin
        chk("t3_supp", FILTER, 0);
        chk("t3_ovr_set", OverrunErr, 1);
      end
      if (k == 4736) chk("t3_tmo_before", TimeoutErr, 0);
      if (k == 4737) chk("t3_tmo_set", TimeoutErr, 1);
    end
    chk("t3_npulses", fpos.size(), 2);
    chk("t3_p0", (fpos.size() > 0) ? fpos[0] : 0, 641);
    chk("t3_p1", (fpos.size() > 1) ? fpos[1] : 0, 897);

    // FIFO vectors: fill, drop, drain, then full push+pop and clear
    tv[0]  = '{1, 16'h0001, 0, 0, 1, 16'h0001, 0};
    tv[1]  = '{1, 16'h0002, 0, 0, 1, 16'h0001, 0};
    tv[2]  = '{1, 16'h0003, 0, 0, 1, 16'h0001, 1};
    tv[3]  = '{0, 16'h0000, 1, 0, 1, 16'h0002, 1};
    tv[4]  = '{0, 16'h0000, 1, 0, 0, 16'h0002, 1};
    tv[5]  = '{0, 16'h0000, 1, 0, 0, 16'h0002, 1};
    tv[6]  = '{1, 16'h0005, 0, 1, 1, 16'h0005, 0};
    tv[7]  = '{1, 16'h0006, 0, 0, 1, 16'h0005, 0};
    tv[8]  = '{1, 16'h0007, 1, 0, 1, 16'h0006, 0};
    tv[9]  = '{0, 16'h0000, 1, 0, 1, 16'h0007, 0};
    tv[10] = '{0, 16'h0000, 1, 0, 0, 16'h0007, 0};
    do_reset(2);
    for (int i = 0; i < 11; i++) begin
      Push = tv[i].push; Dout = tv[i].dout; OutReady = tv[i].rdy; ClrErr = tv[i].clr;
      tick();
      chk("t4_valid", OutValid, tv[i].e_valid);
      chk("t4_data",  OutData,  tv[i].e_data);
      chk("t4_drop",  DropErr,  tv[i].e_drop);
    end
    Push = 0; ClrErr = 0;

    // Spurious push racing a clear leaves SpurErr set; a lone clear drops it
    OutReady = 1; ClrErr = 1;
    tick();
    chk("t5_clr0", SpurErr, 0);
    Push = 1; Dout = 16'hABCD;
    tick();
    chk("t5_spur_kept", SpurErr, 1);
    chk("t5_data", OutData, 16'hABCD);
    Push = 0;
    tick();
    chk("t5_clr1", SpurErr, 0);
    ClrErr = 0;

    // Enable gap delays FILTER; mid-frame reset restarts the sequence
    do_reset(2);
    OutReady = 1;
    fpos.delete();
    for (int c = 1; c <= 800; c++) begin
      Enable = !(c >= 300 && c < 350);
      Reset  = (c == 800);
      tick();
      if (FILTER && c < 800) fpos.push_back(c);
    end
    chk_all_zero("t6_rst");
    chk("t6_first", (fpos.size() > 0) ? fpos[0] : 0, 691);
    Reset = 0; Enable = 1;
    fpos.delete();
    for (int r = 1; r <= 700; r++) begin
      Push = (r == 10); Dout = 16'h5A5A;
      tick();
      if (FILTER) fpos.push_back(r);
      if (r == 10) chk("t6_spur", SpurErr, 1);
    end
    Push = 0;
    chk("t6_npulses", fpos.size(), 1);
    chk("t6_restart", (fpos.size() > 0) ? fpos[0] : 0, 641);

    // Randomized traffic against the model
    do_reset(2);
    for (int i = 0; i < 3000; i++) begin
      Enable   = ($urandom % 16) != 0;
      Push     = (Outstanding != 2'd0) ? (($urandom % 20) == 0) : (($urandom % 200) == 0);
      Dout     = 16'($urandom);
      OutReady = ($urandom % 2) == 1;
      ClrErr   = ($urandom % 200) == 0;
      Reset    = ($urandom % 1500) == 0;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/filt_sched.md
Name: filt_sched

Overview:
Sequencer and result collector for the filt symmetric-FIR block.
- Generates the periodic one-cycle FILTER strobe aligned to the 1-bit sample stream.
- Tracks outstanding filter requests against filt's Push responses.
- Buffers returned Dout words in a 2-entry FIFO with a valid/ready output.
- Flags protocol errors: unsolicited Push, overrun, dropped result, response timeout.

Parameters:
PERIOD, 256, samples (clocks) per filter frame; FILTER period
PHASE, 128, counter value within the frame at which FILTER fires; 0..PERIOD-1
SKIP, 2, number of initial frames with no FILTER (pipeline fill)
MAX_OUT, 2, maximum outstanding FILTER requests without Push
TIMEOUT, 4096, clocks allowed from oldest outstanding request to Push; 16-bit counter

Ports:
Clock  input  1  system clock, all logic on rising edge
Reset  input  1  synchronous, active-high reset
Enable  input  1  frame counter runs while high
ClrErr  input  1  one-cycle pulse, clears sticky error flags
FILTER  output  1  one-cycle request strobe to filt
Push  input  1  filt result-valid strobe
Dout  input  16  filt result, sampled when Push=1
OutValid  output  1  FIFO non-empty
OutData  output  16  FIFO head word
OutReady  input  1  downstream accepts head when OutValid&OutReady
Outstanding  output  2  current outstanding request count
OverrunErr  output  1  sticky: FILTER slot suppressed because Outstanding==MAX_OUT
SpurErr  output  1  sticky: Push seen with Outstanding==0
DropErr  output  1  sticky: Push seen with FIFO full and no pop that cycle
TimeoutErr  output  1  sticky: TIMEOUT expired with Outstanding>0

Behaviour:
- Reset: all outputs 0. Frame counter=0, frame index=0, FIFO empty, timeout counter=0.
- Frame counter (cnt, log2(PERIOD) bits):
  - Increments each clock while Enable=1; wraps PERIOD-1 -> 0.
  - On wrap, frame index increments, saturating at SKIP.
  - Enable=0 holds both counters. Outstanding and FIFO logic keep running.
- FILTER:
  - Registered. High for exactly the one cycle after the edge where cnt==PHASE, Enable=1 and frame index>=SKIP.
  - Defaults: first FILTER in the cycle following the clock at which cnt==128 of frame 2 (2*256+128=640 enabled clocks after reset release). Then one every 256 enabled clocks.
- Suppression: if a FILTER slot occurs while Outstanding==MAX_OUT, FILTER stays 0 and OverrunErr is set.
- Outstanding:
  - +1 on each issued FILTER; -1 on Push when Outstanding>0.
  - Simultaneous FILTER and Push: net unchanged.
  - Push with Outstanding==0: count stays 0, SpurErr set, Dout still captured into the FIFO.
- FIFO (2 x 16):
  - Write Dout on Push. Read on OutValid&OutReady. OutData = head, registered storage.
  - Full with simultaneous push and pop: both occur, no drop.
  - Full, push, no pop: word discarded, DropErr set, contents unchanged.
  - Empty: OutValid=0, OutData holds last value (0 after reset).
- Timeout counter:
  - Clears on each Push and whenever Outstanding==0.
  - Otherwise increments per clock. Reaching TIMEOUT sets TimeoutErr; counter saturates.
- Sticky errors: cleared by ClrErr. An error event in the same cycle as ClrErr leaves the flag set.
- Reset mid-operation: all state returns to reset values on the next edge. In-flight results are lost. A filt Push arriving after reset is reported as SpurErr.
- No arithmetic on Dout; data passes through unmodified, 16 bits.

Test Plan:
1. Reset 3 clocks, Enable=1 continuously -> FILTER pulses exactly in the cycle after cnt==128 of frame 2 (640 enabled clocks after reset release), then every 256 clocks, always width 1; no errors.
2. Model filt: Push with Dout=16'h1234 200 clocks after each FILTER, OutReady=1 -> OutValid one cycle after each Push, OutData=16'h1234, Outstanding toggles 0/1.
3. Never Push, OutReady=1 -> Outstanding reaches 2; third slot suppresses FILTER and sets OverrunErr; TimeoutErr set 4096 clocks after first FILTER.
4. OutReady=0, three Pushes with Dout 16'h0001, 16'h0002, 16'h0003 -> FIFO holds 0001, 0002; DropErr=1. Raise OutReady -> reads 0001 then 0002, then OutValid=0.
5. Push at Outstanding==0 with ClrErr pulsed the same cycle -> SpurErr=1; ClrErr alone next cycle -> SpurErr=0.
6. Drop Enable for 50 clocks mid-frame -> next FILTER delayed exactly 50 clocks. Assert Reset mid-frame -> all outputs 0; FILTER restarts 640 enabled clocks after reset release.
